// File: rtl/relu_maxpool26_if.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool26_if
// Purpose  : start/done handshake and feature-map buses for relu_maxpool26
// Revision : 1.0 - initial release
// ============================================================================
interface relu_maxpool26_if #(
  parameter int IN_SIZE      = 26,
  parameter int OUT_SIZE     = 13,
  parameter int ELEMENT_SIZE = 20
);
  logic                                       en;
  logic [IN_SIZE*IN_SIZE*ELEMENT_SIZE-1:0]    i_featuremap;
  logic [OUT_SIZE*OUT_SIZE*ELEMENT_SIZE-1:0]  o_featuremap;
  logic                                       busy;
  logic                                       done;

  modport master (
    output en, i_featuremap,
    input  o_featuremap, busy, done
  );

  modport slave (
    input  en, i_featuremap,
    output o_featuremap, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/relu_maxpool26.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool26
// Purpose  : ReLU followed by 2x2/stride-2 max pooling, one window per clock
// Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool26 #(
  parameter int IN_SIZE      = 26,
  parameter int OUT_SIZE     = 13,
  parameter int ELEMENT_SIZE = 20
) (
  input  logic            clk,
  input  logic            rst,
  relu_maxpool26_if.slave bus
);

  localparam int c_IN_W     = IN_SIZE * IN_SIZE * ELEMENT_SIZE;
  localparam int c_OUT_W    = OUT_SIZE * OUT_SIZE * ELEMENT_SIZE;
  localparam int c_IDX_W    = $clog2(c_IN_W);
  localparam int c_OIDX_W   = $clog2(c_OUT_W);
  localparam int c_POS_W    = $clog2(OUT_SIZE);
  localparam int c_ROW_STEP = IN_SIZE * ELEMENT_SIZE;
  localparam logic [c_POS_W-1:0] c_LAST = c_POS_W'(OUT_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [c_IN_W-1:0]         r_in;
  logic [c_OUT_W-1:0]        r_out;
  logic [c_POS_W-1:0]        r_row;
  logic [c_POS_W-1:0]        r_col;
  logic                      r_busy;
  logic                      r_done;
  logic                      w_load;
  logic                      w_write;
  logic                      w_last;
  logic                      w_busy_next;
  logic                      w_done_next;

  logic [c_IDX_W-1:0]        w_bit_tl;
  logic [c_IDX_W-1:0]        w_bit_tr;
  logic [c_IDX_W-1:0]        w_bit_bl;
  logic [c_IDX_W-1:0]        w_bit_br;
  logic [c_OIDX_W-1:0]       w_obit;
  logic signed [ELEMENT_SIZE-1:0] w_a;
  logic signed [ELEMENT_SIZE-1:0] w_b;
  logic signed [ELEMENT_SIZE-1:0] w_c;
  logic signed [ELEMENT_SIZE-1:0] w_d;
  logic signed [ELEMENT_SIZE-1:0] w_max_top;
  logic signed [ELEMENT_SIZE-1:0] w_max_bot;
  logic signed [ELEMENT_SIZE-1:0] w_max;
  logic [ELEMENT_SIZE-1:0]   w_relu;

  // Window (r,c) top-left input element is (2r,2c); the others are offsets from it.
  always_comb begin
    w_bit_tl = c_IDX_W'((int'(r_row) * 2 * IN_SIZE + int'(r_col) * 2) * ELEMENT_SIZE);
    w_bit_tr = w_bit_tl + c_IDX_W'(ELEMENT_SIZE);
    w_bit_bl = w_bit_tl + c_IDX_W'(c_ROW_STEP);
    w_bit_br = w_bit_tl + c_IDX_W'(c_ROW_STEP + ELEMENT_SIZE);
    w_obit   = c_OIDX_W'((int'(r_row) * OUT_SIZE + int'(r_col)) * ELEMENT_SIZE);

    w_a = r_in[w_bit_tl +: ELEMENT_SIZE];
    w_b = r_in[w_bit_tr +: ELEMENT_SIZE];
    w_c = r_in[w_bit_bl +: ELEMENT_SIZE];
    w_d = r_in[w_bit_br +: ELEMENT_SIZE];

    w_max_top = (w_a > w_b) ? w_a : w_b;
    w_max_bot = (w_c > w_d) ? w_c : w_d;
    w_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
    w_relu    = w_max[ELEMENT_SIZE-1] ? '0 : w_max;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_write      = 1'b0;
    w_busy_next  = r_busy;
    w_done_next  = r_done;
    w_last       = (r_row == c_LAST) && (r_col == c_LAST);
    case (r_state)
      IDLE: begin
        if (bus.en) begin
          w_load       = 1'b1;
          w_busy_next  = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_write = 1'b1;
        if (w_last) begin
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (!bus.en) begin
          w_done_next  = 1'b0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      if (w_load) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_write) begin
        r_out[w_obit +: ELEMENT_SIZE] <= w_relu;
        if (w_last) begin
          r_row <= '0;
          r_col <= '0;
        end else if (r_col == c_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // The captured input needs no reset: it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_in <= bus.i_featuremap;
    end
  end

  assign bus.o_featuremap = r_out;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool26.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool26
// Purpose  : directed self-checking bench for relu_maxpool26
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool26;

  localparam int IN_SIZE  = 26;
  localparam int OUT_SIZE = 13;
  localparam int ES       = 20;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  relu_maxpool26_if #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .ELEMENT_SIZE(ES)) bus ();

  relu_maxpool26 #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .ELEMENT_SIZE(ES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ES-1:0] out_el(input int r, input int c);
    return bus.o_featuremap[(r * OUT_SIZE + c) * ES +: ES];
  endfunction

  task automatic set_in(input int i, input int j, input logic [ES-1:0] v);
    bus.i_featuremap[(i * IN_SIZE + j) * ES +: ES] = v;
  endtask

  task automatic fill_const(input logic [ES-1:0] v);
    for (int i = 0; i < IN_SIZE; i++)
      for (int j = 0; j < IN_SIZE; j++)
        set_in(i, j, v);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < IN_SIZE; i++)
      for (int j = 0; j < IN_SIZE; j++)
        set_in(i, j, ES'(i * IN_SIZE + j));
  endtask

  task automatic fill_down();
    for (int i = 0; i < IN_SIZE; i++)
      for (int j = 0; j < IN_SIZE; j++)
        set_in(i, j, ES'(1000 - (i * IN_SIZE + j)));
  endtask

  // Starts a run and waits (bounded) for done; lat = edges from start edge to done.
  task automatic run(input bit hold_en, input bit scramble,
                     output int lat, output int busy_cycles, output int overlap);
    lat = -1;
    overlap = 0;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    busy_cycles = bus.busy ? 1 : 0;
    if (!hold_en) bus.en = 1'b0;
    if (scramble) bus.i_featuremap = '1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (bus.busy && bus.done) overlap++;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.en = 1'b0;
    bus.i_featuremap = '0;
    #3;
    n_checks++;
    if (bus.o_featuremap !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got nonzero, expected 0");
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_all_five();
    int lat, bc, ov;
    fill_const(ES'(5));
    run(1'b1, 1'b0, lat, bc, ov);
    n_checks++;
    if (lat !== 169) begin
      n_fail++;
      $display("FAIL five_latency: got %0d expected 169", lat);
    end
    n_checks++;
    if (bc !== 169) begin
      n_fail++;
      $display("FAIL five_busy_cycles: got %0d expected 169", bc);
    end
    n_checks++;
    if (ov !== 0) begin
      n_fail++;
      $display("FAIL five_busy_done_overlap: got %0d expected 0", ov);
    end
    for (int r = 0; r < OUT_SIZE; r++)
      for (int c = 0; c < OUT_SIZE; c++) begin
        n_checks++;
        if (out_el(r, c) !== ES'(5)) begin
          n_fail++;
          $display("FAIL five out(%0d,%0d): got %h expected %h", r, c, out_el(r, c), ES'(5));
        end
      end
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL five_done_drop: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_relu_clamp();
    int lat, bc, ov;
    fill_const(20'hFFFFD);
    run(1'b0, 1'b0, lat, bc, ov);
    n_checks++;
    if (lat !== 169) begin
      n_fail++;
      $display("FAIL clamp_latency: got %0d expected 169", lat);
    end
    for (int r = 0; r < OUT_SIZE; r++)
      for (int c = 0; c < OUT_SIZE; c++) begin
        n_checks++;
        if (out_el(r, c) !== '0) begin
          n_fail++;
          $display("FAIL clamp out(%0d,%0d): got %h expected 0", r, c, out_el(r, c));
        end
      end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_done_drop: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_ramp();
    int lat, bc, ov;
    fill_ramp();
    run(1'b0, 1'b1, lat, bc, ov);
    n_checks++;
    if (out_el(0, 0) !== ES'(27)) begin
      n_fail++;
      $display("FAIL ramp_corner00: got %0d expected 27", out_el(0, 0));
    end
    n_checks++;
    if (out_el(12, 12) !== ES'(675)) begin
      n_fail++;
      $display("FAIL ramp_corner1212: got %0d expected 675", out_el(12, 12));
    end
    for (int r = 0; r < OUT_SIZE; r++)
      for (int c = 0; c < OUT_SIZE; c++) begin
        n_checks++;
        if (out_el(r, c) !== ES'((2 * r + 1) * IN_SIZE + 2 * c + 1)) begin
          n_fail++;
          $display("FAIL ramp out(%0d,%0d): got %0d expected %0d", r, c, out_el(r, c),
                   (2 * r + 1) * IN_SIZE + 2 * c + 1);
        end
      end
    @(posedge clk);
  endtask

  task automatic test_window_edges();
    int lat, bc, ov;
    fill_ramp();
    set_in(0, 0, -20'sd100);
    set_in(0, 1, -20'sd1);
    set_in(1, 0, 20'h7FFFF);
    set_in(1, 1, 20'd0);
    set_in(0, 2, -20'sd5);
    set_in(0, 3, -20'sd7);
    set_in(1, 2, -20'sd1);
    set_in(1, 3, -20'sd2);
    run(1'b0, 1'b0, lat, bc, ov);
    n_checks++;
    if (out_el(0, 0) !== 20'h7FFFF) begin
      n_fail++;
      $display("FAIL window_maxpos: got %h expected 7ffff", out_el(0, 0));
    end
    n_checks++;
    if (out_el(0, 1) !== 20'h0) begin
      n_fail++;
      $display("FAIL window_allneg: got %h expected 0", out_el(0, 1));
    end
    for (int r = 0; r < OUT_SIZE; r++)
      for (int c = 0; c < OUT_SIZE; c++) begin
        if (r == 0 && c < 2) continue;
        n_checks++;
        if (out_el(r, c) !== ES'((2 * r + 1) * IN_SIZE + 2 * c + 1)) begin
          n_fail++;
          $display("FAIL window_other out(%0d,%0d): got %0d expected %0d", r, c, out_el(r, c),
                   (2 * r + 1) * IN_SIZE + 2 * c + 1);
        end
      end
    @(posedge clk);
  endtask

  task automatic test_async_reset();
    int lat, bc, ov;
    fill_ramp();
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_featuremap !== '0) begin
      n_fail++;
      $display("FAIL async_reset_out: got nonzero, expected 0");
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_busy: got %b expected 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_done: got %b expected 0", bus.done);
    end
    @(negedge clk);
    rst = 1'b1;
    fill_const(ES'(11));
    run(1'b0, 1'b0, lat, bc, ov);
    n_checks++;
    if (lat !== 169) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d expected 169", lat);
    end
    for (int r = 0; r < OUT_SIZE; r++)
      for (int c = 0; c < OUT_SIZE; c++) begin
        n_checks++;
        if (out_el(r, c) !== ES'(11)) begin
          n_fail++;
          $display("FAIL post_reset out(%0d,%0d): got %0d expected 11", r, c, out_el(r, c));
        end
      end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov;
    logic [OUT_SIZE*OUT_SIZE*ES-1:0] exp_nine;
    for (int k = 0; k < OUT_SIZE * OUT_SIZE; k++) exp_nine[k * ES +: ES] = ES'(9);
    fill_const(ES'(9));
    run(1'b1, 1'b0, lat, bc, ov);
    fill_ramp();
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.o_featuremap !== exp_nine) begin
        n_fail++;
        $display("FAIL hold_en cycle %0d: got done=%b busy=%b out00=%0d expected done=1 busy=0 out=9",
                 n, bus.done, bus.busy, out_el(0, 0));
      end
    end
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.o_featuremap !== exp_nine) begin
      n_fail++;
      $display("FAIL hold_release: got done=%b out00=%0d expected done=0 out=9", bus.done, out_el(0, 0));
    end
    fill_down();
    run(1'b0, 1'b0, lat, bc, ov);
    n_checks++;
    if (lat !== 169) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d expected 169", lat);
    end
    for (int r = 0; r < OUT_SIZE; r++)
      for (int c = 0; c < OUT_SIZE; c++) begin
        n_checks++;
        if (out_el(r, c) !== ES'(1000 - 2 * r * IN_SIZE - 2 * c)) begin
          n_fail++;
          $display("FAIL restart out(%0d,%0d): got %0d expected %0d", r, c, out_el(r, c),
                   1000 - 2 * r * IN_SIZE - 2 * c);
        end
      end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL final_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_all_five();
    test_relu_clamp();
    test_ramp();
    test_window_edges();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
